// File: rtl/mem_sys_pkg.sv
// mem_sys_pkg: shared types and constants for the bit-serial memory arbiter.
// Holds the x/w address widths, bank count, arbiter state enum, the latched
// operation record and a saturating counter helper used by the optional
// statistics block.
package mem_sys_pkg;

    localparam int AW_X      = 10;
    localparam int AW_W      = 20;
    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;

    localparam logic TGT_X = 1'b0;
    localparam logic TGT_W = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic              tgt;
        logic [BANK_W-1:0] bank;
        logic [AW_W-1:0]   addr;
        logic              wdata;
    } mem_op_t;

    // Increment a 16-bit counter when en is set, sticking at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mem_sys_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a one-bit priority pointer.
// Ports:
//   i_clk, i_rst : clock, synchronous active-low reset (pointer favours 0)
//   i_req[1:0]   : request vector, bit N = client N
//   i_en         : arbitration slot active; pointer may move only then
//   o_gnt[1:0]   : one-hot grant (combinational from i_req and pointer)
// The pointer flips only on a real conflict, so a lone requester never
// disturbs the fairness order of the other client.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_ptr;   // 0: client 0 wins a conflict, 1: client 1 wins

    // Grant selection: lone requester wins, conflicts go to the pointer.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

    // Pointer register: hand priority to the loser after each conflict.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_en && (i_req == 2'b11)) begin
            r_ptr <= ~r_ptr;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/mem_sys_arb.sv
// mem_sys_arb: two-client arbiter/sequencer for the bit-serial memory system
// (4 x-banks of 1K bits, 4 w-banks of 1M bits). c0 is the loader, c1 the
// compute engine. Each op runs IDLE -> ISSUE -> RESP: strobe one cycle after
// the request is seen, ack one cycle later.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   cN_req/we/tgt/bank/addr/wdata : client N request fields (held until ack)
//   cN_ack, cN_rdata         : one-cycle completion pulse and read bit
//   m_read_rq_x/m_write_rq_x/m_read_rq_w/m_write_rq_w : memory strobes
//   m_rw_address_x, m_rw_address, m_sel_x, m_sel_w   : address / bank select
//   m_write_data, m_en       : write bit and bank enable
//   m_read_data_x, m_read_data_w : memory read data, sampled during ISSUE
// Optional feature, macro ARB_STATS_EN: adds stat_clr input and saturating
// stat_rd / stat_wr / stat_conflict counters.
module mem_sys_arb
    import mem_sys_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic              c0_tgt,
    input  logic [1:0]        c0_bank,
    input  logic [AW_W-1:0]   c0_addr,
    input  logic              c0_wdata,
    output logic              c0_ack,
    output logic              c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic              c1_tgt,
    input  logic [1:0]        c1_bank,
    input  logic [AW_W-1:0]   c1_addr,
    input  logic              c1_wdata,
    output logic              c1_ack,
    output logic              c1_rdata,
`ifdef ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_wr,
    output logic [15:0]       stat_conflict,
`endif
    output logic              m_read_rq_x,
    output logic              m_write_rq_x,
    output logic              m_read_rq_w,
    output logic              m_write_rq_w,
    output logic [AW_X-1:0]   m_rw_address_x,
    output logic [AW_W-1:0]   m_rw_address,
    output logic              m_write_data,
    output logic [1:0]        m_sel_x,
    output logic [1:0]        m_sel_w,
    output logic              m_en,
    input  logic              m_read_data_x,
    input  logic              m_read_data_w
);

    state_t  r_state;
    state_t  w_next;
    mem_op_t r_op;
    mem_op_t w_op_sel;
    logic    r_gnt_c1;     // granted client of the op in flight
    logic [1:0] w_gnt;
    logic    w_idle;
    logic    w_take;
    logic    w_rd_bit;
    logic    w_unused_op;

    assign w_idle = (r_state == IDLE);
    assign w_take = w_idle && (w_gnt != 2'b00);

    rr_arb2 u_rr_arb2 (
        .i_clk (clk),
        .i_rst (rst),
        .i_req ({c1_req, c0_req}),
        .i_en  (w_idle),
        .o_gnt (w_gnt)
    );

    // Request fields of the client being granted this cycle.
    always_comb begin
        w_op_sel = '0;
        if (w_gnt[1]) begin
            w_op_sel = '{we: c1_we, tgt: c1_tgt, bank: c1_bank, addr: c1_addr, wdata: c1_wdata};
        end else begin
            w_op_sel = '{we: c0_we, tgt: c0_tgt, bank: c0_bank, addr: c0_addr, wdata: c0_wdata};
        end
    end

    // Read bit from whichever memory the op in flight targets.
    assign w_rd_bit = (r_op.tgt == TGT_W) ? m_read_data_w : m_read_data_x;

    // Bank/address copies live in the m_* registers, which hold per path.
    assign w_unused_op = ^{r_op.bank, r_op.addr};
    assign m_write_data = r_op.wdata;

    // Next-state logic for the three-phase op sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next = ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, op register and all registered memory/client outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_op           <= '0;
            r_gnt_c1       <= 1'b0;
            m_read_rq_x    <= 1'b0;
            m_write_rq_x   <= 1'b0;
            m_read_rq_w    <= 1'b0;
            m_write_rq_w   <= 1'b0;
            m_rw_address_x <= '0;
            m_rw_address   <= '0;
            m_sel_x        <= 2'b00;
            m_sel_w        <= 2'b00;
            m_en           <= 1'b0;
            c0_ack         <= 1'b0;
            c1_ack         <= 1'b0;
            c0_rdata       <= 1'b0;
            c1_rdata       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    c0_ack   <= 1'b0;
                    c1_ack   <= 1'b0;
                    c0_rdata <= 1'b0;
                    c1_rdata <= 1'b0;
                    if (w_take) begin
                        r_op         <= w_op_sel;
                        r_gnt_c1     <= w_gnt[1];
                        m_en         <= 1'b1;
                        m_read_rq_x  <= ~w_op_sel.we & (w_op_sel.tgt == TGT_X);
                        m_write_rq_x <=  w_op_sel.we & (w_op_sel.tgt == TGT_X);
                        m_read_rq_w  <= ~w_op_sel.we & (w_op_sel.tgt == TGT_W);
                        m_write_rq_w <=  w_op_sel.we & (w_op_sel.tgt == TGT_W);
                        // Only the addressed path moves; the other holds.
                        if (w_op_sel.tgt == TGT_X) begin
                            m_sel_x        <= w_op_sel.bank;
                            m_rw_address_x <= w_op_sel.addr[AW_X-1:0];
                        end else begin
                            m_sel_w      <= w_op_sel.bank;
                            m_rw_address <= w_op_sel.addr;
                        end
                    end
                end
                ISSUE: begin
                    m_en         <= 1'b0;
                    m_read_rq_x  <= 1'b0;
                    m_write_rq_x <= 1'b0;
                    m_read_rq_w  <= 1'b0;
                    m_write_rq_w <= 1'b0;
                    c0_ack       <= ~r_gnt_c1;
                    c1_ack       <=  r_gnt_c1;
                    c0_rdata     <= ~r_gnt_c1 & ~r_op.we & w_rd_bit;
                    c1_rdata     <=  r_gnt_c1 & ~r_op.we & w_rd_bit;
                end
                RESP: begin
                    c0_ack   <= 1'b0;
                    c1_ack   <= 1'b0;
                    c0_rdata <= 1'b0;
                    c1_rdata <= 1'b0;
                end
                default: begin
                    m_en         <= 1'b0;
                    m_read_rq_x  <= 1'b0;
                    m_write_rq_x <= 1'b0;
                    m_read_rq_w  <= 1'b0;
                    m_write_rq_w <= 1'b0;
                    c0_ack       <= 1'b0;
                    c1_ack       <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating op and conflict counters with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst || stat_clr) begin
            stat_rd       <= 16'd0;
            stat_wr       <= 16'd0;
            stat_conflict <= 16'd0;
        end else begin
            stat_rd       <= sat_inc16(stat_rd, (r_state == RESP) && !r_op.we);
            stat_wr       <= sat_inc16(stat_wr, (r_state == RESP) &&  r_op.we);
            stat_conflict <= sat_inc16(stat_conflict, w_idle && c0_req && c1_req);
        end
    end
`endif

endmodule

// File: tb/tb_mem_sys_arb.sv
// tb_mem_sys_arb: randomized and directed bench for mem_sys_arb. A
// transaction-level reference model decides which client wins each free slot
// and in which cycles the strobe and ack must appear; all outputs are
// compared every cycle on the falling edge.
module tb_mem_sys_arb;

    logic        clk;
    logic        rst;
    logic        c0_req, c0_we, c0_tgt, c0_wdata, c0_ack, c0_rdata;
    logic        c1_req, c1_we, c1_tgt, c1_wdata, c1_ack, c1_rdata;
    logic [1:0]  c0_bank, c1_bank;
    logic [19:0] c0_addr, c1_addr;
    logic        m_read_rq_x, m_write_rq_x, m_read_rq_w, m_write_rq_w;
    logic [9:0]  m_rw_address_x;
    logic [19:0] m_rw_address;
    logic        m_write_data, m_en, m_read_data_x, m_read_data_w;
    logic [1:0]  m_sel_x, m_sel_w;
`ifdef ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_rd, stat_wr, stat_conflict;
`endif

    mem_sys_arb dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_tgt(c0_tgt), .c0_bank(c0_bank),
        .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_tgt(c1_tgt), .c1_bank(c1_bank),
        .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
`ifdef ARB_STATS_EN
        .stat_clr(stat_clr), .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_conflict(stat_conflict),
`endif
        .m_read_rq_x(m_read_rq_x), .m_write_rq_x(m_write_rq_x),
        .m_read_rq_w(m_read_rq_w), .m_write_rq_w(m_write_rq_w),
        .m_rw_address_x(m_rw_address_x), .m_rw_address(m_rw_address),
        .m_write_data(m_write_data), .m_sel_x(m_sel_x), .m_sel_w(m_sel_w),
        .m_en(m_en), .m_read_data_x(m_read_data_x), .m_read_data_w(m_read_data_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a fixed function of the full bit location.
    function automatic logic mem_bit(input logic tgt, input logic [1:0] bank, input logic [19:0] addr);
        return ~^{tgt, bank, addr};
    endfunction

    assign m_read_data_x = mem_bit(1'b0, m_sel_x, {10'b0, m_rw_address_x});
    assign m_read_data_w = mem_bit(1'b1, m_sel_w, m_rw_address);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Client stimulus state
    int          cyc = 0;
    bit          rand_en = 1'b0;
    int          req_pct = 70;
    logic        pend   [2];
    logic        op_we  [2];
    logic        op_tgt [2];
    logic [1:0]  op_bank[2];
    logic [19:0] op_addr[2];
    logic        op_wd  [2];

    // Reference model state
    int          issue_cyc, resp_cyc, busy_until;
    int          fav;          // client that wins the next conflict
    int          exp_cl;
    logic        exp_we, exp_tgt, exp_rdata;
    logic [1:0]  ex_sel_x, ex_sel_w;
    logic [9:0]  ex_addr_x;
    logic [19:0] ex_addr_w;
    logic        ex_wdata;
    int          m_rd, m_wr, m_conf;
    bit          did_rst;

    task automatic model_reset();
        fav = 0; issue_cyc = -1; resp_cyc = -1; busy_until = cyc + 1;
        ex_sel_x = 2'b0; ex_sel_w = 2'b0; ex_addr_x = 10'b0; ex_addr_w = 20'b0; ex_wdata = 1'b0;
        m_rd = 0; m_wr = 0; m_conf = 0;
    endtask

    task automatic model_decide();
        int w;
        logic [19:0] a;
        if (cyc >= busy_until && (c0_req || c1_req)) begin
            if (c0_req && c1_req) begin
                w = fav; fav = 1 - fav; m_conf++;
            end else begin
                w = c1_req ? 1 : 0;
            end
            exp_cl  = w;
            exp_we  = (w == 1) ? c1_we  : c0_we;
            exp_tgt = (w == 1) ? c1_tgt : c0_tgt;
            a       = (w == 1) ? c1_addr : c0_addr;
            ex_wdata = (w == 1) ? c1_wdata : c0_wdata;
            if (exp_tgt == 1'b0) begin
                ex_sel_x  = (w == 1) ? c1_bank : c0_bank;
                ex_addr_x = a[9:0];
                exp_rdata = exp_we ? 1'b0 : mem_bit(1'b0, ex_sel_x, {10'b0, a[9:0]});
            end else begin
                ex_sel_w  = (w == 1) ? c1_bank : c0_bank;
                ex_addr_w = a;
                exp_rdata = exp_we ? 1'b0 : mem_bit(1'b1, ex_sel_w, a);
            end
            if (exp_we) m_wr++; else m_rd++;
            issue_cyc = cyc + 1; resp_cyc = cyc + 2; busy_until = cyc + 3;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] stb;
        bit         iss, a0, a1;
        iss = (cyc == issue_cyc);
        stb = 4'b0000;
        if (iss) begin
            case ({exp_we, exp_tgt})
                2'b00:   stb = 4'b1000;
                2'b10:   stb = 4'b0100;
                2'b01:   stb = 4'b0010;
                default: stb = 4'b0001;
            endcase
        end
        a0 = (cyc == resp_cyc) && (exp_cl == 0);
        a1 = (cyc == resp_cyc) && (exp_cl == 1);
        chk("m_en", 32'(m_en), 32'(iss));
        chk("strobes", 32'({m_read_rq_x, m_write_rq_x, m_read_rq_w, m_write_rq_w}), 32'(stb));
        chk("m_sel_x", 32'(m_sel_x), 32'(ex_sel_x));
        chk("m_addr_x", 32'(m_rw_address_x), 32'(ex_addr_x));
        chk("m_sel_w", 32'(m_sel_w), 32'(ex_sel_w));
        chk("m_addr_w", 32'(m_rw_address), 32'(ex_addr_w));
        chk("m_wdata", 32'(m_write_data), 32'(ex_wdata));
        chk("c0_ack", 32'(c0_ack), 32'(a0));
        chk("c1_ack", 32'(c1_ack), 32'(a1));
        chk("c0_rdata", 32'(c0_rdata), 32'(a0 ? exp_rdata : 1'b0));
        chk("c1_rdata", 32'(c1_rdata), 32'(a1 ? exp_rdata : 1'b0));
    endtask

    task automatic new_rand_op(input int c);
        pend[c] = 1'b1; op_we[c] = 1'($urandom); op_tgt[c] = 1'($urandom);
        op_bank[c] = 2'($urandom); op_addr[c] = 20'($urandom); op_wd[c] = 1'($urandom);
    endtask

    task automatic clients_update();
        if (!rst) begin
            pend[0] = 1'b0; pend[1] = 1'b0;
        end else begin
            if (c0_ack) pend[0] = 1'b0;
            if (c1_ack) pend[1] = 1'b0;
            for (int c = 0; c < 2; c++)
                if (!pend[c] && rand_en && ($urandom_range(0, 99) < req_pct)) new_rand_op(c);
        end
    endtask

    task automatic drive();
        c0_req = pend[0]; c0_we = op_we[0]; c0_tgt = op_tgt[0];
        c0_bank = op_bank[0]; c0_addr = op_addr[0]; c0_wdata = op_wd[0];
        c1_req = pend[1]; c1_we = op_we[1]; c1_tgt = op_tgt[1];
        c1_bank = op_bank[1]; c1_addr = op_addr[1]; c1_wdata = op_wd[1];
    endtask

    task automatic load_op(input int c, input logic we, input logic tgt, input logic [1:0] bank,
                           input logic [19:0] addr, input logic wd);
        pend[c] = 1'b1; op_we[c] = we; op_tgt[c] = tgt; op_bank[c] = bank;
        op_addr[c] = addr; op_wd[c] = wd;
        drive();
    endtask

    // One clock: check, model, stimulus. rst is held low across the edge on request.
    task automatic cycle_step(input bit chk_en, input bit rst_at_issue, input bit force_rst);
        @(negedge clk);
        if (chk_en) check_outputs();
        if (force_rst || (rst_at_issue && cyc == issue_cyc)) begin
            rst = 1'b0;
            if (!force_rst) did_rst = 1'b1;
        end
        if (!rst) model_reset(); else model_decide();
        clients_update();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive();
        cyc++;
    endtask

    task automatic check_stats();
`ifdef ARB_STATS_EN
        chk("stat_rd", 32'(stat_rd), 32'(m_rd));
        chk("stat_wr", 32'(stat_wr), 32'(m_wr));
        chk("stat_conflict", 32'(stat_conflict), 32'(m_conf));
`endif
    endtask

    initial begin
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 1'b0; op_we[c] = 1'b0; op_tgt[c] = 1'b0;
            op_bank[c] = 2'b0; op_addr[c] = 20'b0; op_wd[c] = 1'b0;
        end
        drive();
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        did_rst = 1'b0;
        model_reset();
        cycle_step(1'b0, 1'b0, 1'b1);
        cycle_step(1'b0, 1'b0, 1'b1);
        cycle_step(1'b1, 1'b0, 1'b0);   // reset state checked here

        // Directed ops: x write, w read, truncated x address, then a conflict.
        rand_en = 1'b0;
        load_op(0, 1'b1, 1'b0, 2'd2, 20'h00155, 1'b1);
        repeat (4) cycle_step(1'b1, 1'b0, 1'b0);
        load_op(1, 1'b0, 1'b1, 2'd3, 20'hABCDE, 1'b0);
        repeat (4) cycle_step(1'b1, 1'b0, 1'b0);
        load_op(0, 1'b0, 1'b0, 2'd1, 20'hFFC05, 1'b0);
        repeat (4) cycle_step(1'b1, 1'b0, 1'b0);
        load_op(0, 1'b1, 1'b1, 2'd0, 20'h12345, 1'b1);
        load_op(1, 1'b1, 1'b0, 2'd3, 20'h003FF, 1'b0);
        repeat (8) cycle_step(1'b1, 1'b0, 1'b0);
        check_stats();
`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        cycle_step(1'b1, 1'b0, 1'b0);
        stat_clr = 1'b0;
        m_rd = 0; m_wr = 0; m_conf = 0;
        cycle_step(1'b1, 1'b0, 1'b0);
        check_stats();
`endif

        // Both clients saturating from reset: strict alternation expected.
        cycle_step(1'b1, 1'b0, 1'b1);
        rand_en = 1'b1; req_pct = 100;
        repeat (14) cycle_step(1'b1, 1'b0, 1'b0);

        // Reset while an op is in ISSUE; pointer must come back favouring c0.
        for (int i = 0; i < 10 && !did_rst; i++) cycle_step(1'b1, 1'b1, 1'b0);
        chk("rst_in_issue_hit", 32'(did_rst), 32'd1);
        repeat (12) cycle_step(1'b1, 1'b0, 1'b0);

        // Random traffic.
        req_pct = 60;
        repeat (600) cycle_step(1'b1, 1'b0, 1'b0);
        rand_en = 1'b0;
        repeat (8) cycle_step(1'b1, 1'b0, 1'b0);
        check_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
